// File: rtl/gate_lib_pkg.sv
// Field layout of the registered gate snapshot bus shared by the gate-library leaves.
// Bit indices let consumers pick a single gate out of gates_q by name.
package gate_lib_pkg;

    localparam int GATES_W     = 6;

    localparam int IDX_A_NOT   = 0;
    localparam int IDX_B_NOT   = 1;
    localparam int IDX_AB_OR   = 2;
    localparam int IDX_AB_AND  = 3;
    localparam int IDX_AB_NAND = 4;
    localparam int IDX_AB_NOR  = 5;

endpackage

// File: rtl/nand2_cell.sv
// Purpose: 2-input NAND primitive, the only gate used to build the library's logic functions.
// Latency: combinational, zero cycles.
// Backpressure: none; pure combinational leaf.
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_to_other.sv
// Purpose: derives NOT/OR/AND/NAND/NOR of a and b from NAND cells only, plus a registered snapshot.
// Latency: gate outputs are combinational; gates_q lags the gate outputs by one clk cycle.
// Backpressure: none; gates_q reloads on every rising clk edge while rst is low.
module nand_to_other
    import gate_lib_pkg::*;
(
    output logic               a_not,
    output logic               b_not,
    output logic               ab_or,
    output logic               ab_and,
    output logic               ab_nand,
    output logic               ab_nor,
    input  logic               a,
    input  logic               b,
    input  logic               clk,
    input  logic               rst,
    output logic [GATES_W-1:0] gates_q
);

    nand2_cell u_a_not   (.a(a),       .b(a),       .y(a_not));
    nand2_cell u_b_not   (.a(b),       .b(b),       .y(b_not));
    nand2_cell u_ab_nand (.a(a),       .b(b),       .y(ab_nand));
    nand2_cell u_ab_and  (.a(ab_nand), .b(ab_nand), .y(ab_and));
    // De Morgan: a | b == ~(~a & ~b)
    nand2_cell u_ab_or   (.a(a_not),   .b(b_not),   .y(ab_or));
    nand2_cell u_ab_nor  (.a(ab_or),   .b(ab_or),   .y(ab_nor));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gates_q <= '0;
        end else begin
            gates_q[IDX_A_NOT]   <= a_not;
            gates_q[IDX_B_NOT]   <= b_not;
            gates_q[IDX_AB_OR]   <= ab_or;
            gates_q[IDX_AB_AND]  <= ab_and;
            gates_q[IDX_AB_NAND] <= ab_nand;
            gates_q[IDX_AB_NOR]  <= ab_nor;
        end
    end

endmodule

// File: tb/tb_nand_to_other.sv
// Bench for nand_to_other: directed truth-table, reset and snapshot-timing cases, then random vectors
// checked against a truth-table model built from integer arithmetic.
module tb_nand_to_other;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       clk_run;
    logic       a_not, b_not, ab_or, ab_and, ab_nand, ab_nor;
    logic [5:0] gates_q;
    logic [5:0] comb_bus;

    int n_checks = 0;
    int n_errors = 0;

    nand_to_other dut (
        .a_not   (a_not),
        .b_not   (b_not),
        .ab_or   (ab_or),
        .ab_and  (ab_and),
        .ab_nand (ab_nand),
        .ab_nor  (ab_nor),
        .a       (a),
        .b       (b),
        .clk     (clk),
        .rst     (rst),
        .gates_q (gates_q)
    );

    assign comb_bus = {ab_nor, ab_nand, ab_and, ab_or, b_not, a_not};

    // Clock only toggles while clk_run is set, so the sweep can run with clk idle.
    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    // Expected {nor,nand,and,or,b_not,a_not} from integer arithmetic on the operands.
    function automatic logic [5:0] ref_bus(input int av, input int bv);
        int and_v;
        int or_v;
        and_v = av * bv;
        or_v  = (av + bv > 0) ? 1 : 0;
        return {(or_v == 0), (and_v == 0), (and_v == 1), (or_v == 1), (bv == 0), (av == 0)};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_invariants(input string tag);
        chk({tag, "_nand_inv"}, {5'b0, ab_nand}, {5'b0, ~ab_and});
        chk({tag, "_nor_inv"},  {5'b0, ab_nor},  {5'b0, ~ab_or});
        chk({tag, "_nor_dm"},   {5'b0, ab_nor},  {5'b0, a_not & b_not});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        logic [5:0] exp_q;
        int         av;
        int         bv;

        clk_run = 1'b0;
        rst     = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        #2 rst  = 1'b1;
        #1 chk("reset_q", gates_q, 6'b000000);
        rst = 1'b0;

        // Truth-table sweep with clk idle and rst low.
        for (int i = 0; i < 4; i++) begin
            av = i / 2;
            bv = i % 2;
            a  = av[0];
            b  = bv[0];
            #10;
            chk($sformatf("sweep_ab%0d%0d", av, bv), comb_bus, ref_bus(av, bv));
            chk_invariants("sweep");
        end
        chk("idle_clk_q", gates_q, 6'b000000);

        // Reset held with clock running: snapshot stays clear.
        rst = 1'b1;
        a = 1'b1;
        b = 1'b1;
        clk_run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_held_q", gates_q, 6'b000000);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_load_11", gates_q, 6'b001100);

        // ab=01 loads, then a mid-cycle change to 10 must wait for the next edge.
        a = 1'b0;
        b = 1'b1;
        @(negedge clk);
        chk("load_01", gates_q, ref_bus(0, 1));
        #2;
        a = 1'b1;
        b = 1'b0;
        #1;
        chk("hold_mid_cycle", gates_q, ref_bus(0, 1));
        chk("comb_10", comb_bus, ref_bus(1, 0));
        @(negedge clk);
        chk("load_10", gates_q, ref_bus(1, 0));

        // Asynchronous reset in the high phase, away from any edge.
        a = 1'b0;
        b = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", gates_q, 6'b000000);
        chk("async_rst_comb", comb_bus, 6'b110011);
        @(negedge clk);
        rst = 1'b0;

        // Random vectors: snapshot must equal the previous cycle's expected bus.
        av = int'($urandom_range(0, 1));
        bv = int'($urandom_range(0, 1));
        a  = av[0];
        b  = bv[0];
        exp_q = ref_bus(av, bv);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("rand_q", gates_q, exp_q);
            chk("rand_comb", comb_bus, ref_bus(av, bv));
            chk_invariants("rand");
            av = int'($urandom_range(0, 1));
            bv = int'($urandom_range(0, 1));
            a  = av[0];
            b  = bv[0];
            exp_q = ref_bus(av, bv);
        end

        clk_run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
